dm_block_responder: RTL and testbench
=====================================

// Module: dm_block_responder
// PURPOSE
//  Memory-side responder for the core's data-memory port: serves word reads/writes
//  (MemRead/MemWrite) and 256-bit line fills/evictions (dBlkRead/dBlkWrite).
//  Sits between the pipelined MIPS top and the data store; drives data_read_fDM and
//  block_read_fDM back to the core.
//  Models access latency with a busy/ready handshake that the core uses to freeze.
// PARAMETERS
//  ADDR_W   10  word-address bits of the backing store (depth 2**ADDR_W x 32b)
//  LATENCY  4   wait cycles before any transfer; legal range 1..15
// PORTS
//  CLK               in   1    clock, rising edge
//  RESET             in   1    asynchronous, active-low reset
//  MemRead           in   1    word read request
//  MemWrite          in   1    word write request
//  dBlkRead          in   1    line read (fill) request
//  dBlkWrite         in   1    line write (evict) request
//  data_address_2DM  in   32   byte address
//  data_write_2DM    in   32   word write data
//  block_write_2DM   in   256  line write data; word i = bits [32i+31:32i]
//  data_read_fDM     out  32   word read data, registered
//  block_read_fDM    out  256  line read data, registered, same word order
//  dm_busy           out  1    request accepted and not yet completed
//  dm_ready          out  1    one-cycle completion pulse
// BEHAVIOUR
//  - Reset (RESET=0): state IDLE; all outputs 0; counters 0. RAM contents are not cleared.
//    Reset mid-operation aborts the transfer. A half-written line stays partially written.
//  - Requests are sampled only in IDLE.
//    Priority when several request lines are high: dBlkWrite > dBlkRead > MemWrite > MemRead.
//    The losers are dropped, not queued.
//  - At acceptance, latch op, address, data_write_2DM and block_write_2DM.
//    Request inputs are ignored while dm_busy=1.
//  - Address: word ops use addr[ADDR_W+1:2]; addr[1:0] is ignored.
//    Block ops use base = {addr[ADDR_W+1:5],3'b000}; addr[4:0] is ignored.
//    Upper address bits are ignored, so addresses alias modulo the store size.
//  - FSM: IDLE -> WAIT -> (XFER, block ops only) -> RESP -> IDLE.
//    IDLE: dm_busy=0. A request accepted at edge T gives WAIT and dm_busy=1 from T+1.
//    WAIT: runs exactly LATENCY cycles on a down-counter.
//    XFER: 8 beats, beat index i=0..7, one RAM access per beat at base+i.
//          Block read: buffer word i <= RAM[base+i].
//          Block write: RAM[base+i] <= latched word i.
//    RESP: one cycle with dm_ready=1 and dm_busy=1.
//          Word read: data_read_fDM <= RAM word, visible in the RESP cycle.
//          Word write: RAM written at the end of RESP.
//          Block read: block_read_fDM <= buffer, visible in the RESP cycle.
//    A request present in the cycle after RESP (back in IDLE) is accepted normally.
//    There is no back-to-back acceptance in RESP itself.
//  - Completion timing, with acceptance at edge T: word op dm_ready in cycle T+LATENCY+1.
//    Block op dm_ready in cycle T+LATENCY+9.
//  - data_read_fDM and block_read_fDM hold their last value until the next read of the same kind.
//    Writes never change them.
//  - Beat counter is 3 bits and wraps 7->0 at XFER exit. Base+i never crosses the line boundary.
// STRUCTURE
//  - Shared package mips_mem_pkg holds:
//    state encodings IDLE/WAIT/XFER/RESP; op encodings OP_RD/OP_WR/OP_BRD/OP_BWR;
//    BLK_WORDS=8 and BLK_BITS=256.
//  - Sub-module dm_word_ram: single-port synchronous 32-bit RAM with 1-cycle read, no reset.
//  - Top level holds the FSM, the latency counter, the beat counter and the line buffers.
// TESTING
//  1. Reset with RESET=0 for 3 cycles; then word-read 0x40 with LATENCY=4.
//     -> All outputs stay 0 during reset.
//     -> dm_busy rises at T+1; dm_ready pulses at T+5; data_read_fDM shows the preloaded value.
//  2. MemWrite addr 0x104 data 0xDEADBEEF, then MemRead addr 0x107.
//     -> Read returns 0xDEADBEEF, because the low address bits are ignored.
//  3. dBlkWrite addr 0x20F with words 0x0..0x7 (word i = i), then dBlkRead addr 0x200.
//     -> block_read_fDM = same 256b; dm_ready at T+13 for each.
//  4. Assert dBlkRead and MemWrite together.
//     -> Only the block read executes; RAM is unchanged; exactly one dm_ready pulse.
//  5. Pull RESET low during XFER beat 3 of a block write.
//     -> Outputs go to 0 immediately; state is IDLE.
//     -> RAM words 0..2 are new and 3..7 are old; the next request completes normally.
//  6. Toggle MemWrite while dm_busy=1.
//     -> The request is ignored; RAM is unchanged at that address.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared FSM/op encodings and line geometry for the data-memory responder
package mips_mem_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_BRD = 2'd2;
  localparam logic [1:0] OP_BWR = 2'd3;
  localparam int BLK_WORDS = 8;
  localparam int BLK_BITS  = 256;
endpackage

// File: rtl/dm_word_ram.sv
// dm_word_ram: single-port synchronous 32-bit RAM, one-cycle read, contents survive reset
module dm_word_ram import mips_mem_pkg::*; #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);
  logic [31:0] mem_q [2**ADDR_W];
  // read-before-write port: rdata_o shows the old word on a write cycle
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/dm_block_responder.sv
// dm_block_responder: latency-modelled word/line responder on the core's data-memory port
module dm_block_responder import mips_mem_pkg::*; #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic                dBlkRead,
  input  logic                dBlkWrite,
  input  logic [31:0]         data_address_2DM,
  input  logic [31:0]         data_write_2DM,
  input  logic [BLK_BITS-1:0] block_write_2DM,
  output logic [31:0]         data_read_fDM,
  output logic [BLK_BITS-1:0] block_read_fDM,
  output logic                dm_busy,
  output logic                dm_ready
);
  logic [1:0] state_q, state_d, op_q, op_d, req_op;
  logic [3:0] lat_q, lat_d;
  logic [2:0] beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d, req_addr, ram_addr;
  logic [31:0] wdata_q, wdata_d, data_read_q, data_read_d, ram_rdata, ram_wdata;
  logic [BLK_BITS-1:0] wblk_q, wblk_d, rbuf_q, rbuf_d, block_read_q, block_read_d;
  logic req, req_blk, blk, ram_we, unused_addr;
  assign req      = dBlkWrite | dBlkRead | MemWrite | MemRead;
  assign req_blk  = dBlkWrite | dBlkRead;
  assign req_op   = dBlkWrite ? OP_BWR : dBlkRead ? OP_BRD : MemWrite ? OP_WR : OP_RD;
  assign req_addr = req_blk ? {data_address_2DM[ADDR_W+1:5], 3'b000} : data_address_2DM[ADDR_W+1:2];
  assign unused_addr = ^{data_address_2DM[31:ADDR_W+2], data_address_2DM[1:0]};
  assign blk = op_q[1];
  // the RAM is addressed from the live request in IDLE so read data is ready even for LATENCY=1;
  // line reads run one word ahead so the last word lands in the buffer at the XFER->RESP edge
  assign ram_addr  = state_q == IDLE ? req_addr : !blk ? addr_q :
                     {addr_q[ADDR_W-1:3], (state_q == XFER && op_q == OP_BRD) ? beat_q + 3'd1 : beat_q};
  assign ram_we    = (state_q == XFER && op_q == OP_BWR) || (state_q == RESP && op_q == OP_WR);
  assign ram_wdata = blk ? wblk_q[{beat_q, 5'b0} +: 32] : wdata_q;
  dm_word_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i  (CLK),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );
  // next-state: accept in IDLE, count down WAIT, stream 8 beats in XFER, pulse RESP
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    lat_d        = lat_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wblk_d       = wblk_q;
    rbuf_d       = rbuf_q;
    data_read_d  = data_read_q;
    block_read_d = block_read_q;
    if (state_q == IDLE && req) begin
      state_d = WAIT;
      op_d    = req_op;
      lat_d   = 4'(LATENCY);
      addr_d  = req_addr;
      wdata_d = data_write_2DM;
      wblk_d  = block_write_2DM;
    end
    if (state_q == WAIT) begin
      lat_d = lat_q - 4'd1;
      if (lat_q == 4'd1) state_d = blk ? XFER : RESP;
      if (lat_q == 4'd1 && op_q == OP_RD) data_read_d = ram_rdata;
    end
    if (state_q == XFER) begin
      beat_d = beat_q + 3'd1;
      if (op_q == OP_BRD) rbuf_d[{beat_q, 5'b0} +: 32] = ram_rdata;
      if (beat_q == 3'd7) state_d = RESP;
      if (beat_q == 3'd7 && op_q == OP_BRD) block_read_d = rbuf_d;
    end
    if (state_q == RESP) state_d = IDLE;
  end
  // state registers; reset aborts any transfer in flight
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      op_q         <= OP_RD;
      lat_q        <= '0;
      beat_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wblk_q       <= '0;
      rbuf_q       <= '0;
      data_read_q  <= '0;
      block_read_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      lat_q        <= lat_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wblk_q       <= wblk_d;
      rbuf_q       <= rbuf_d;
      data_read_q  <= data_read_d;
      block_read_q <= block_read_d;
    end
  end
  assign data_read_fDM  = data_read_q;
  assign block_read_fDM = block_read_q;
  assign dm_busy        = state_q != IDLE;
  assign dm_ready       = state_q == RESP;
endmodule

// File: tb/tb_dm_block_responder.sv
// tb_dm_block_responder: directed checks of latency, priority, aliasing and reset abort
module tb_dm_block_responder;
  logic CLK = 1'b0, RESET = 1'b0;
  logic MemRead = 1'b0, MemWrite = 1'b0, dBlkRead = 1'b0, dBlkWrite = 1'b0;
  logic [31:0] data_address_2DM = '0, data_write_2DM = '0, data_read_fDM;
  logic [255:0] block_write_2DM = '0, block_read_fDM;
  logic dm_busy, dm_ready;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  dm_block_responder #(.ADDR_W(10), .LATENCY(4)) dut (
    .CLK(CLK), .RESET(RESET), .MemRead(MemRead), .MemWrite(MemWrite),
    .dBlkRead(dBlkRead), .dBlkWrite(dBlkWrite), .data_address_2DM(data_address_2DM),
    .data_write_2DM(data_write_2DM), .block_write_2DM(block_write_2DM),
    .data_read_fDM(data_read_fDM), .block_read_fDM(block_read_fDM),
    .dm_busy(dm_busy), .dm_ready(dm_ready)
  );
  function automatic logic [255:0] mk_line(input logic [31:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = b + 32'(i);
    return r;
  endfunction
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic bw, input logic br, input logic mw, input logic mr,
                       input logic [31:0] a, input logic [31:0] wd, input logic [255:0] bwd, input string tag);
    @(negedge CLK);
    dBlkWrite = bw; dBlkRead = br; MemWrite = mw; MemRead = mr;
    data_address_2DM = a; data_write_2DM = wd; block_write_2DM = bwd;
    @(posedge CLK);
    @(negedge CLK);
    dBlkWrite = 0; dBlkRead = 0; MemWrite = 0; MemRead = 0;
    chk({tag, " busy@T+1"}, 256'(dm_busy), 256'(1));
  endtask
  task automatic wait_ready(input int n0, input int exp_n, input string tag);
    int n = n0;
    while (dm_ready !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, " ready cycle"}, 256'(n), 256'(exp_n));
    chk({tag, " busy in RESP"}, 256'(dm_busy), 256'(1));
    @(negedge CLK);
    chk({tag, " ready pulse"}, 256'({dm_ready, dm_busy}), 256'(0));
  endtask
  initial begin
    int pulses;
    logic [255:0] exp_line;
    #1 dut.u_ram.mem_q[16] = 32'h1234_5678;
    repeat (3) begin
      @(negedge CLK);
      chk("reset outputs", {data_read_fDM, block_read_fDM[223:0]} | 256'({dm_busy, dm_ready}), 256'(0));
    end
    RESET = 1'b1;
    start(0, 0, 0, 1, 32'h40, 0, 0, "t1 rd");
    wait_ready(1, 5, "t1 rd");
    chk("t1 data", 256'(data_read_fDM), 256'h1234_5678);
    chk("t1 block untouched", block_read_fDM, 256'(0));
    start(0, 0, 1, 0, 32'h104, 32'hDEAD_BEEF, 0, "t2 wr");
    wait_ready(1, 5, "t2 wr");
    chk("t2 write keeps data_read", 256'(data_read_fDM), 256'h1234_5678);
    start(0, 0, 0, 1, 32'h107, 0, 0, "t2 rd");
    wait_ready(1, 5, "t2 rd");
    chk("t2 low bits ignored", 256'(data_read_fDM), 256'hDEAD_BEEF);
    start(1, 0, 0, 0, 32'h20F, 0, mk_line(0), "t3 bwr");
    wait_ready(1, 13, "t3 bwr");
    chk("t3 bwr keeps block_read", block_read_fDM, 256'(0));
    start(0, 1, 0, 0, 32'h200, 0, 0, "t3 brd");
    wait_ready(1, 13, "t3 brd");
    chk("t3 line", block_read_fDM, mk_line(0));
    start(0, 0, 0, 1, 32'hFFFF_F20C, 0, 0, "t3 alias");
    wait_ready(1, 5, "t3 alias");
    chk("t3 alias word3", 256'(data_read_fDM), 256'(3));
    start(0, 1, 1, 0, 32'h204, 32'hBAD0_BAD0, mk_line(32'h55), "t4 prio");
    wait_ready(1, 13, "t4 prio");
    chk("t4 line", block_read_fDM, mk_line(0));
    pulses = 0;
    repeat (5) begin
      @(negedge CLK);
      if (dm_ready === 1'b1) pulses++;
    end
    chk("t4 single pulse", 256'(pulses), 256'(0));
    start(0, 0, 0, 1, 32'h204, 0, 0, "t4 rd");
    wait_ready(1, 5, "t4 rd");
    chk("t4 loser dropped", 256'(data_read_fDM), 256'(1));
    start(1, 0, 0, 0, 32'h300, 0, mk_line(32'h100), "t5 old");
    wait_ready(1, 13, "t5 old");
    start(1, 0, 0, 0, 32'h300, 0, mk_line(32'hA0), "t5 new");
    repeat (7) @(negedge CLK);
    chk("t5 busy beat3", 256'(dm_busy), 256'(1));
    RESET = 1'b0;
    #1;
    chk("t5 async reset outputs", {data_read_fDM, block_read_fDM[223:0]} | 256'({dm_busy, dm_ready}), 256'(0));
    chk("t5 reset block_read top", 256'(block_read_fDM[255:224]), 256'(0));
    @(negedge CLK);
    RESET = 1'b1;
    start(0, 1, 0, 0, 32'h300, 0, 0, "t5 brd");
    wait_ready(1, 13, "t5 brd");
    exp_line = mk_line(32'h100);
    for (int i = 0; i < 3; i++) exp_line[32*i +: 32] = 32'hA0 + 32'(i);
    chk("t5 partial line", block_read_fDM, exp_line);
    start(0, 0, 0, 1, 32'h40, 0, 0, "t6 rd");
    MemWrite = 1'b1; data_address_2DM = 32'h40; data_write_2DM = 32'h5555_AAAA;
    @(negedge CLK);
    MemWrite = 1'b0;
    @(negedge CLK);
    MemWrite = 1'b1;
    @(negedge CLK);
    MemWrite = 1'b0;
    wait_ready(4, 5, "t6 rd");
    chk("t6 data", 256'(data_read_fDM), 256'h1234_5678);
    repeat (3) @(negedge CLK);
    chk("t6 no late accept", 256'(dm_busy), 256'(0));
    start(0, 0, 0, 1, 32'h40, 0, 0, "t6 reread");
    wait_ready(1, 5, "t6 reread");
    chk("t6 ram unchanged", 256'(data_read_fDM), 256'h1234_5678);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
